coeff_token_encoder: RTL and testbench

Serializing coeff_token encoder for the CAVLC entropy path, covering the 0 <= nC < 2 table of H.264 Table 9-5. It accepts one (TotalCoeff, TrailingOnes) pair per handshake and looks up the variable-length codeword. It then emits the codeword MSB-first, one bit per accepted output beat, into the downstream bitstream packer. It is the transmit-side counterpart of the coeff_token decode LUTs.

---
 rtl/cavlc_pkg.sv | 33 +++
 rtl/coeff_token_encoder_if.sv | 29 ++
 rtl/coeff_token_encoder_lut02.sv | 88 ++++++++
 rtl/coeff_token_encoder.sv | 104 ++++++++++
 tb/tb_coeff_token_encoder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cavlc_pkg.sv
// Shared CAVLC coeff_token encoder types and constants.
//   MAX_LEN        : longest codeword, sizes the shift register
//   CNT_W          : bit-counter width, holds 0..MAX_LEN
//   lut_entry_t    : {code (right-justified), len} returned by the code LUT
//   state_e        : encoder FSM states
package cavlc_pkg;

    localparam int unsigned MAX_LEN        = 16;
    localparam int unsigned TOTALCOEFF_W   = 5;
    localparam int unsigned TRAILINGONES_W = 2;
    localparam int unsigned CODE_W         = 16;
    localparam int unsigned LEN_W          = 5;
    localparam int unsigned CNT_W          = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } lut_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Builds a LUT entry from plain integers so the table reads like the standard.
    function automatic lut_entry_t mk_entry(input int unsigned code, input int unsigned len);
        lut_entry_t e;
        e.code = CODE_W'(code);
        e.len  = LEN_W'(len);
        return e;
    endfunction

endpackage

// File: rtl/coeff_token_encoder_if.sv
// Token-in / bit-out handshake bundle of the coeff_token encoder.
//   in_valid/in_ready   : token handshake, payload total_coeff/trailing_ones
//   out_valid/out_ready : bit handshake, payload out_bit/out_last
//   error               : one-cycle pulse when an illegal token was accepted
// slave = encoder view, master = upstream source / downstream packer view.
interface coeff_token_encoder_if;
    import cavlc_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [TOTALCOEFF_W-1:0]   total_coeff;
    logic [TRAILINGONES_W-1:0] trailing_ones;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_bit;
    logic                      out_last;
    logic                      error;

    modport slave (
        input  in_valid, total_coeff, trailing_ones, out_ready,
        output in_ready, out_valid, out_bit, out_last, error
    );

    modport master (
        output in_valid, total_coeff, trailing_ones, out_ready,
        input  in_ready, out_valid, out_bit, out_last, error
    );

endinterface

// File: rtl/coeff_token_encoder_lut02.sv
// coeff_token codeword table for 0 <= nC < 2 (62 legal entries).
//   total_coeff, trailing_ones : token
//   entry_c                    : {code right-justified, len}, zero when illegal
//   legal_c                    : token exists in the table
module coeff_token_code_lut02
    import cavlc_pkg::*;
(
    input  logic [TOTALCOEFF_W-1:0]   total_coeff,
    input  logic [TRAILINGONES_W-1:0] trailing_ones,
    output lut_entry_t                entry_c,
    output logic                      legal_c
);

    logic [TOTALCOEFF_W+TRAILINGONES_W-1:0] idx;

    // Index is total_coeff*4 + trailing_ones; every missing index is illegal.
    always_comb begin
        idx     = {total_coeff, trailing_ones};
        entry_c = '0;
        legal_c = 1'b1;
        case (idx)
            7'd0:  entry_c = mk_entry(1, 1);
            7'd4:  entry_c = mk_entry(5, 6);
            7'd5:  entry_c = mk_entry(1, 2);
            7'd8:  entry_c = mk_entry(7, 8);
            7'd9:  entry_c = mk_entry(4, 6);
            7'd10: entry_c = mk_entry(1, 3);
            7'd12: entry_c = mk_entry(7, 9);
            7'd13: entry_c = mk_entry(6, 8);
            7'd14: entry_c = mk_entry(5, 7);
            7'd15: entry_c = mk_entry(3, 5);
            7'd16: entry_c = mk_entry(7, 10);
            7'd17: entry_c = mk_entry(6, 9);
            7'd18: entry_c = mk_entry(5, 8);
            7'd19: entry_c = mk_entry(3, 6);
            7'd20: entry_c = mk_entry(7, 11);
            7'd21: entry_c = mk_entry(6, 10);
            7'd22: entry_c = mk_entry(5, 9);
            7'd23: entry_c = mk_entry(4, 7);
            7'd24: entry_c = mk_entry(15, 13);
            7'd25: entry_c = mk_entry(6, 11);
            7'd26: entry_c = mk_entry(5, 10);
            7'd27: entry_c = mk_entry(4, 8);
            7'd28: entry_c = mk_entry(11, 13);
            7'd29: entry_c = mk_entry(14, 13);
            7'd30: entry_c = mk_entry(5, 11);
            7'd31: entry_c = mk_entry(4, 9);
            7'd32: entry_c = mk_entry(8, 13);
            7'd33: entry_c = mk_entry(10, 13);
            7'd34: entry_c = mk_entry(13, 13);
            7'd35: entry_c = mk_entry(4, 10);
            7'd36: entry_c = mk_entry(15, 14);
            7'd37: entry_c = mk_entry(14, 14);
            7'd38: entry_c = mk_entry(9, 13);
            7'd39: entry_c = mk_entry(4, 11);
            7'd40: entry_c = mk_entry(11, 14);
            7'd41: entry_c = mk_entry(10, 14);
            7'd42: entry_c = mk_entry(13, 14);
            7'd43: entry_c = mk_entry(12, 13);
            7'd44: entry_c = mk_entry(15, 15);
            7'd45: entry_c = mk_entry(14, 15);
            7'd46: entry_c = mk_entry(9, 14);
            7'd47: entry_c = mk_entry(12, 14);
            7'd48: entry_c = mk_entry(11, 15);
            7'd49: entry_c = mk_entry(10, 15);
            7'd50: entry_c = mk_entry(13, 15);
            7'd51: entry_c = mk_entry(8, 14);
            7'd52: entry_c = mk_entry(15, 16);
            7'd53: entry_c = mk_entry(1, 15);
            7'd54: entry_c = mk_entry(9, 15);
            7'd55: entry_c = mk_entry(12, 15);
            7'd56: entry_c = mk_entry(11, 16);
            7'd57: entry_c = mk_entry(14, 16);
            7'd58: entry_c = mk_entry(13, 16);
            7'd59: entry_c = mk_entry(8, 15);
            7'd60: entry_c = mk_entry(7, 16);
            7'd61: entry_c = mk_entry(10, 16);
            7'd62: entry_c = mk_entry(9, 16);
            7'd63: entry_c = mk_entry(12, 16);
            7'd64: entry_c = mk_entry(4, 16);
            7'd65: entry_c = mk_entry(6, 16);
            7'd66: entry_c = mk_entry(5, 16);
            7'd67: entry_c = mk_entry(8, 16);
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/coeff_token_encoder.sv
// Serializing CAVLC coeff_token encoder (0 <= nC < 2 table).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : token in, codeword bits out MSB-first, error pulse
// in_ready is the only combinational output; everything else is a flop.
module coeff_token_encoder
    import cavlc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    coeff_token_encoder_if.slave bus
);

    state_e             state_q,     state_d;
    logic [MAX_LEN-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q,  out_last_d;
    logic               error_q,     error_d;

    lut_entry_t         lut_entry;
    logic               lut_legal;
    logic               in_ready_c;
    logic               load;
    logic [MAX_LEN-1:0] load_shift;
    logic [CNT_W-1:0]   load_shamt;

    coeff_token_code_lut02 u_lut (
        .total_coeff   (bus.total_coeff),
        .trailing_ones (bus.trailing_ones),
        .entry_c       (lut_entry),
        .legal_c       (lut_legal)
    );

    // Next state: shift out on accepted beats, reload on the last beat when a legal token waits.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        error_d     = 1'b0;
        load        = 1'b0;
        in_ready_c  = (state_q == IDLE) | (out_last_q & bus.out_ready);
        load_shamt  = CNT_W'(MAX_LEN) - CNT_W'(lut_entry.len);
        load_shift  = MAX_LEN'(lut_entry.code) << load_shamt;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (lut_legal) load = 1'b1;
                    else           error_d = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.out_ready) begin
                    shift_d = {shift_q[MAX_LEN-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (out_last_q) begin
                        state_d = IDLE;
                        if (bus.in_valid) begin
                            if (lut_legal) load = 1'b1;
                            else           error_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Left-align the codeword so the MSB is always at the top of the register.
        if (load) begin
            shift_d = load_shift;
            cnt_d   = CNT_W'(lut_entry.len);
            state_d = SHIFT;
        end

        out_valid_d = (state_d == SHIFT);
        out_last_d  = (state_d == SHIFT) && (cnt_d == CNT_W'(1));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = shift_q[MAX_LEN-1];
    assign bus.out_last  = out_last_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_coeff_token_encoder.sv
// Scoreboard bench for coeff_token_encoder: stimulus pushes expected beats/errors,
// a negedge monitor pops and compares whenever a beat is accepted or error is high.
module tb_coeff_token_encoder;
    import cavlc_pkg::*;

    typedef struct packed {
        logic b;
        logic l;
    } beat_t;

    logic clk;
    logic rst_n;
    coeff_token_encoder_if bus ();

    coeff_token_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t exp_q[$];
    int    err_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    beats = 0;
    int    last_beat_cyc = 0;
    int    hold_checks = 0;
    bit    ready_toggle = 1'b0;
    logic  hold_pend = 1'b0;
    logic  hold_bit, hold_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Downstream packer ready: constantly 1, or toggling every cycle.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) bus.out_ready = ~bus.out_ready;
            else              bus.out_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: accepted beats, held outputs under backpressure, error pulses.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                hold_checks++;
                chk("hold_stable", {29'd0, bus.out_valid, bus.out_bit, bus.out_last},
                    {29'd0, 1'b1, hold_bit, hold_last});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got bit=%0b last=%0b with nothing expected at cycle %0d",
                             bus.out_bit, bus.out_last, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_bit_last", {30'd0, bus.out_bit, bus.out_last}, {30'd0, e.b, e.l});
                end
                beats++;
                last_beat_cyc = cyc;
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_bit  = bus.out_bit;
            hold_last = bus.out_last;
            if (bus.error) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_error: error high with none expected at cycle %0d", cyc);
                end else begin
                    chk("error_cycle", 32'(cyc), 32'(err_q.pop_front()));
                end
            end
        end
    end

    // Queue the expected bits (first n_push of them, all if negative) and hand over the token.
    task automatic send(input int tc, input int to, input string code, input int n_push, output int acc);
        beat_t e;
        byte   ch;
        int    n;
        int    lim;
        lim = (n_push < 0) ? code.len() : n_push;
        for (int i = 0; i < lim; i++) begin
            ch  = code[i];
            e.b = (ch == 8'h31);
            e.l = (i == code.len() - 1);
            exp_q.push_back(e);
        end
        bus.in_valid      = 1'b1;
        bus.total_coeff   = 5'(tc);
        bus.trailing_ones = 2'(to);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: token (%0d,%0d) never accepted", tc, to);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc          = cyc;
        bus.in_valid = 1'b0;
        if (code.len() == 0) err_q.push_back(acc);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 || err_q.size() != 0) begin
            @(posedge clk);
            #2;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL drain_%s: %0d beats and %0d errors still expected", name, exp_q.size(), err_q.size());
                exp_q.delete();
                err_q.delete();
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int acc;
        int b0;
        int h0;
        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.total_coeff   = '0;
        bus.trailing_ones = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_bit",   32'(bus.out_bit),   32'd0);
        chk("reset_out_last",  32'(bus.out_last),  32'd0);
        chk("reset_error",     32'(bus.error),     32'd0);
        @(posedge clk);
        #1;

        // Shortest codeword, then idle handshake state.
        send(0, 0, "1", -1, acc);
        drain("t00");
        chk("idle_in_ready",  32'(bus.in_ready),  32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back tokens: 10 beats on consecutive cycles from the first acceptance.
        b0 = beats;
        send(1, 1, "01", -1, acc);
        send(2, 2, "001", -1, b0);
        send(3, 3, "00011", -1, b0);
        b0 = beats - 0;
        drain("b2b");
        chk("b2b_last_cycle", 32'(last_beat_cyc - acc), 32'd9);

        // Backpressure: outputs hold while out_ready is low, exactly 6 beats.
        b0 = beats;
        h0 = hold_checks;
        ready_toggle = 1'b1;
        send(1, 0, "000101", -1, acc);
        drain("toggle");
        ready_toggle = 1'b0;
        @(posedge clk);
        #2;
        chk("toggle_beats", 32'(beats - b0), 32'd6);
        chk("toggle_held",  32'(hold_checks > h0), 32'd1);

        // Illegal tokens: one error pulse each, no bits, then normal encoding.
        send(2, 3, "", -1, acc);
        send(17, 0, "", -1, acc);
        repeat (3) begin
            @(negedge clk);
            chk("illegal_out_valid", 32'(bus.out_valid), 32'd0);
        end
        drain("illegal");
        send(0, 0, "1", -1, acc);
        drain("after_illegal");

        // Long codewords. (16,0) is 0000000000000100; 0000000000001111 is the (13,0) entry.
        send(16, 0, "0000000000000100", -1, acc);
        drain("t16_0");
        send(13, 0, "0000000000001111", -1, acc);
        send(13, 1, "000000000000001", -1, acc);
        send(5, 3, "0000100", -1, acc);
        drain("long");

        // Illegal token arriving on a last beat: error, back to IDLE, then a fresh token.
        send(1, 1, "01", -1, acc);
        send(1, 2, "", -1, acc);
        send(0, 0, "1", -1, acc);
        drain("illegal_on_last");

        // Asynchronous reset during beat 3 of (1,0); no residue afterwards.
        send(1, 0, "000101", 3, acc);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out_bit",   32'(bus.out_bit),   32'd0);
        chk("abort_out_last",  32'(bus.out_last),  32'd0);
        chk("abort_error",     32'(bus.error),     32'd0);
        chk("abort_seen_beats", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(1, 1, "01", -1, acc);
        drain("post_reset");
        chk("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
